// File: rtl/conv_layer_sequencer_pkg.sv
// Shared definitions for the convolution layer sequencer.
//   seq_state_t       : 3-bit sequencer state encoding
//   CW_DEFAULT        : default width of row/column/stride config fields
//   KW_DEFAULT        : default width of the kernel-size field
//   PIPE_LAT_DEFAULT  : default cycles from last tap enable to valid PE output
package conv_layer_sequencer_pkg;

  localparam int unsigned CW_DEFAULT       = 8;
  localparam int unsigned KW_DEFAULT       = 4;
  localparam int unsigned PIPE_LAT_DEFAULT = 2;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StMac,
    StDrain,
    StWrite,
    StDone
  } seq_state_t;

endpackage

// File: rtl/conv_seq_addr_gen.sv
// Combinational address generator for the convolution layer sequencer.
// Keeps the multipliers out of the FSM. All arithmetic is unsigned at 32 bits
// and then truncated to AB bits, so addresses wrap silently.
//   orow_i, ocol_i   : current output position
//   kr_i, kc_i       : current kernel tap
//   k_i              : kernel size K
//   stride_i         : input row pitch in buffer words
//   out_cols_i       : output columns C
//   in_base_i        : neuron read base
//   out_base_i       : neuron write base
//   k_base_i         : kernel buffer base
//   k_addr_o         : k_base + kr*K + kc
//   rd_addr_o        : in_base + (orow+kr)*stride + (ocol+kc)
//   wr_addr_o        : out_base + orow*C + ocol
module conv_seq_addr_gen #(
  parameter int unsigned AB = 11,
  parameter int unsigned CW = 8,
  parameter int unsigned KW = 4
) (
  input  logic [CW-1:0] orow_i,
  input  logic [CW-1:0] ocol_i,
  input  logic [KW-1:0] kr_i,
  input  logic [KW-1:0] kc_i,
  input  logic [KW-1:0] k_i,
  input  logic [CW-1:0] stride_i,
  input  logic [CW-1:0] out_cols_i,
  input  logic [AB-1:0] in_base_i,
  input  logic [AB-1:0] out_base_i,
  input  logic [AB-1:0] k_base_i,
  output logic [AB-1:0] k_addr_o,
  output logic [AB-1:0] rd_addr_o,
  output logic [AB-1:0] wr_addr_o
);

  always_comb begin
    k_addr_o  = AB'(32'(k_base_i) + 32'(kr_i) * 32'(k_i) + 32'(kc_i));
    rd_addr_o = AB'(32'(in_base_i) + (32'(orow_i) + 32'(kr_i)) * 32'(stride_i)
                    + 32'(ocol_i) + 32'(kc_i));
    wr_addr_o = AB'(32'(out_base_i) + 32'(orow_i) * 32'(out_cols_i) + 32'(ocol_i));
  end

endmodule

// File: rtl/conv_layer_sequencer.sv
// Sequences one convolution layer: walks output positions and K x K kernel
// taps, issuing kernel/neuron read addresses with PE clear/enable strobes,
// waits PIPE_LAT cycles for the mesh, writes one result per position, and
// swaps the neuron read/write buffers when the layer completes.
//
// Ports:
//   CLK, RST_N        : clock, asynchronous active-low reset
//   start, abort      : layer start pulse (IDLE only), synchronous abort
//   cfg_*             : layer configuration, latched on an accepted start
//   busy, done        : high LOAD..DONE; one-cycle completion pulse
//   cfg_err           : one-cycle pulse when K, R or C is zero
//   kBuffAddress      : kernel buffer address (valid with peEnable)
//   nReadAddress      : neuron read address (valid with peEnable)
//   nWriteAddress     : neuron write address (valid with nWWrite)
//   nWWrite           : neuron write strobe
//   readBufferSelect  : which neuron buffer is the read side
//   doPooling         : route conv output through the pooling unit
//   peClear, peEnable : PE accumulator load-on-first-tap, MAC enable
//   stat_cycles       : busy-cycle counter, only with CONV_SEQ_STATS_EN
//
// Optional feature macro: CONV_SEQ_STATS_EN adds stat_cycles.
// PIPE_LAT must be at least 1. DEPTH describes the mesh (D = 1 << DEPTH);
// the tap walk itself does not depend on it.
module conv_layer_sequencer
  import conv_layer_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned AB       = 11,
  parameter int unsigned CW       = CW_DEFAULT,
  parameter int unsigned KW       = KW_DEFAULT,
  parameter int unsigned PIPE_LAT = PIPE_LAT_DEFAULT
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          start,
  input  logic          abort,
  input  logic [KW-1:0] cfg_k,
  input  logic [CW-1:0] cfg_out_rows,
  input  logic [CW-1:0] cfg_out_cols,
  input  logic [CW-1:0] cfg_in_stride,
  input  logic [AB-1:0] cfg_in_base,
  input  logic [AB-1:0] cfg_out_base,
  input  logic [AB-1:0] cfg_k_base,
  input  logic          cfg_pool,
  output logic          busy,
  output logic          done,
  output logic          cfg_err,
  output logic [AB-1:0] kBuffAddress,
  output logic [AB-1:0] nReadAddress,
  output logic [AB-1:0] nWriteAddress,
  output logic          nWWrite,
  output logic          readBufferSelect,
  output logic          doPooling,
  output logic          peClear,
  output logic          peEnable
`ifdef CONV_SEQ_STATS_EN
  ,
  output logic [31:0]   stat_cycles
`endif
);

  localparam int unsigned DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  seq_state_t    state_q, state_d;
  logic [CW-1:0] orow_q, orow_d, ocol_q, ocol_d;
  logic [KW-1:0] kr_q, kr_d, kc_q, kc_d;
  logic [DW-1:0] drain_q, drain_d;

  // Latched layer configuration
  logic [KW-1:0] k_q, k_d;
  logic [CW-1:0] rows_q, rows_d, cols_q, cols_d, stride_q, stride_d;
  logic [AB-1:0] in_base_q, in_base_d, out_base_q, out_base_d, k_base_q, k_base_d;
  logic          pool_q, pool_d;

  logic          rbs_q, rbs_d;
  logic          cfg_err_q, cfg_err_d;

  // Addresses hold their last driven value outside MAC/WRITE
  logic [AB-1:0] kaddr_q, kaddr_d, raddr_q, raddr_d, waddr_q, waddr_d;
  logic [AB-1:0] gen_kaddr, gen_raddr, gen_waddr;

  conv_seq_addr_gen #(
    .AB (AB),
    .CW (CW),
    .KW (KW)
  ) u_addr_gen (
    .orow_i     (orow_q),
    .ocol_i     (ocol_q),
    .kr_i       (kr_q),
    .kc_i       (kc_q),
    .k_i        (k_q),
    .stride_i   (stride_q),
    .out_cols_i (cols_q),
    .in_base_i  (in_base_q),
    .out_base_i (out_base_q),
    .k_base_i   (k_base_q),
    .k_addr_o   (gen_kaddr),
    .rd_addr_o  (gen_raddr),
    .wr_addr_o  (gen_waddr)
  );

  always_comb begin
    state_d    = state_q;
    orow_d     = orow_q;
    ocol_d     = ocol_q;
    kr_d       = kr_q;
    kc_d       = kc_q;
    drain_d    = drain_q;
    k_d        = k_q;
    rows_d     = rows_q;
    cols_d     = cols_q;
    stride_d   = stride_q;
    in_base_d  = in_base_q;
    out_base_d = out_base_q;
    k_base_d   = k_base_q;
    pool_d     = pool_q;
    rbs_d      = rbs_q;
    cfg_err_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // abort in the same cycle drops the start
        if (start && !abort) begin
          k_d        = cfg_k;
          rows_d     = cfg_out_rows;
          cols_d     = cfg_out_cols;
          stride_d   = cfg_in_stride;
          in_base_d  = cfg_in_base;
          out_base_d = cfg_out_base;
          k_base_d   = cfg_k_base;
          pool_d     = cfg_pool;
          state_d    = StLoad;
        end
      end
      StLoad: begin
        if (k_q == '0 || rows_q == '0 || cols_q == '0) begin
          cfg_err_d = 1'b1;
          state_d   = StIdle;
        end else begin
          orow_d  = '0;
          ocol_d  = '0;
          kr_d    = '0;
          kc_d    = '0;
          state_d = StMac;
        end
      end
      StMac: begin
        if (kc_q == k_q - KW'(1)) begin
          kc_d = '0;
          if (kr_q == k_q - KW'(1)) begin
            kr_d    = '0;
            drain_d = '0;
            state_d = StDrain;
          end else begin
            kr_d = kr_q + KW'(1);
          end
        end else begin
          kc_d = kc_q + KW'(1);
        end
      end
      StDrain: begin
        if (drain_q == DW'(PIPE_LAT - 1)) begin
          state_d = StWrite;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      StWrite: begin
        state_d = StMac;
        if (ocol_q == cols_q - CW'(1)) begin
          ocol_d = '0;
          if (orow_q == rows_q - CW'(1)) begin
            state_d = StDone;
          end else begin
            orow_d = orow_q + CW'(1);
          end
        end else begin
          ocol_d = ocol_q + CW'(1);
        end
      end
      StDone: begin
        rbs_d   = ~rbs_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Abort overrides everything except the strobes of the current cycle
    if (abort && state_q != StIdle) begin
      state_d   = StIdle;
      rbs_d     = rbs_q;
      cfg_err_d = 1'b0;
    end
  end

  always_comb begin
    kaddr_d          = (state_q == StMac)   ? gen_kaddr : kaddr_q;
    raddr_d          = (state_q == StMac)   ? gen_raddr : raddr_q;
    waddr_d          = (state_q == StWrite) ? gen_waddr : waddr_q;
    busy             = (state_q != StIdle);
    done             = (state_q == StDone) && !abort;
    cfg_err          = cfg_err_q;
    kBuffAddress     = kaddr_d;
    nReadAddress     = raddr_d;
    nWriteAddress    = waddr_d;
    nWWrite          = (state_q == StWrite);
    readBufferSelect = rbs_q;
    doPooling        = busy && pool_q;
    peEnable         = (state_q == StMac);
    peClear          = (state_q == StMac) && (kr_q == '0) && (kc_q == '0);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= StIdle;
      orow_q     <= '0;
      ocol_q     <= '0;
      kr_q       <= '0;
      kc_q       <= '0;
      drain_q    <= '0;
      k_q        <= '0;
      rows_q     <= '0;
      cols_q     <= '0;
      stride_q   <= '0;
      in_base_q  <= '0;
      out_base_q <= '0;
      k_base_q   <= '0;
      pool_q     <= 1'b0;
      rbs_q      <= 1'b0;
      cfg_err_q  <= 1'b0;
      kaddr_q    <= '0;
      raddr_q    <= '0;
      waddr_q    <= '0;
    end else begin
      state_q    <= state_d;
      orow_q     <= orow_d;
      ocol_q     <= ocol_d;
      kr_q       <= kr_d;
      kc_q       <= kc_d;
      drain_q    <= drain_d;
      k_q        <= k_d;
      rows_q     <= rows_d;
      cols_q     <= cols_d;
      stride_q   <= stride_d;
      in_base_q  <= in_base_d;
      out_base_q <= out_base_d;
      k_base_q   <= k_base_d;
      pool_q     <= pool_d;
      rbs_q      <= rbs_d;
      cfg_err_q  <= cfg_err_d;
      kaddr_q    <= kaddr_d;
      raddr_q    <= raddr_d;
      waddr_q    <= waddr_d;
    end
  end

`ifdef CONV_SEQ_STATS_EN
  logic [31:0] stat_q, stat_d;

  always_comb begin
    stat_d = stat_q;
    if (state_q == StIdle && start && !abort) begin
      stat_d = '0;
    end else if (busy && stat_q != '1) begin
      stat_d = stat_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stat_cycles = stat_q;
`endif

endmodule

// File: doc/conv_layer_sequencer.md
Name: conv_layer_sequencer

Overview:
- Sequences one convolution layer over the PE mesh, neuron buffer swapper and kernel buffer.
- Walks output positions and kernel taps, issuing the kernel/neuron read addresses and PE clear/enable strobes, then one write-back per output position.
- On completion it swaps the neuron read/write buffers so the next layer reads this layer's outputs.
- Sits between the master controller (start/config/done) and the buffer/conv datapath.

Parameters:
DEPTH, 2, log2 of mesh dimension; D = 1<<DEPTH derived, not overridable
AB, 11, buffer address width (kernel and neuron buffers)
CW, 8, width of row/column/stride config fields
KW, 4, width of kernel-size field
PIPE_LAT, 2, cycles from last tap enable to valid partialSumOut

Ports:
CLK  in  1  clock, all state on rising edge
RST_N  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; accepted only in IDLE
abort  in  1  synchronous abort to IDLE
cfg_k  in  KW  kernel size K (K×K taps)
cfg_out_rows  in  CW  output rows R
cfg_out_cols  in  CW  output columns C
cfg_in_stride  in  CW  input row pitch in buffer words
cfg_in_base  in  AB  neuron read base
cfg_out_base  in  AB  neuron write base
cfg_k_base  in  AB  kernel buffer base
cfg_pool  in  1  enable pooling path for this layer
busy  out  1  high from LOAD through DONE inclusive
done  out  1  one-cycle pulse in DONE
cfg_err  out  1  one-cycle pulse on zero-size config
kBuffAddress  out  AB  kernel buffer address
nReadAddress  out  AB  neuron read address
nWriteAddress  out  AB  neuron write address
nWWrite  out  1  write strobe to write buffer
readBufferSelect  out  1  selects which neuron buffer is read side
doPooling  out  1  routes conv output through pooling unit
peClear  out  1  first tap of a window: PE accumulator loads instead of adds
peEnable  out  1  MAC enable for the mesh

Behaviour:
- Reset: all outputs 0, readBufferSelect=0, state IDLE, counters 0. Reset mid-operation discards everything; no done, no swap.
- States: IDLE, LOAD, MAC, DRAIN, WRITE, DONE.
- IDLE:
  - On start, latch all cfg_* → LOAD.
  - start while not IDLE is ignored.
- LOAD (1 cycle):
  - If latched K, R or C is 0: pulse cfg_err, return to IDLE; no done, no swap.
  - Otherwise clear orow, ocol, kr, kc → MAC.
- MAC:
  - One tap per cycle, K*K cycles per output position.
  - kc increments and wraps at K-1 into kr.
  - peEnable=1; peClear=1 only when kr=kc=0.
  - kBuffAddress = k_base + kr*K + kc.
  - nReadAddress = in_base + (orow+kr)*stride + (ocol+kc).
  - After the tap kr=kc=K-1 → DRAIN.
- DRAIN: PIPE_LAT cycles with peEnable=0 → WRITE.
- WRITE (1 cycle):
  - nWWrite=1; nWriteAddress = out_base + orow*C + ocol.
  - Advance ocol; wrap at C-1 into orow.
  - If this was the last position (orow=R-1, ocol=C-1) → DONE, else → MAC.
- DONE (1 cycle): done=1, readBufferSelect toggles → IDLE.
- Per-position latency: K*K + PIPE_LAT + 1 cycles. Layer latency: 2 + R*C*(K*K+PIPE_LAT+1) cycles from start to done (LOAD and DONE included).
- Address arithmetic is unsigned and computed at full width, then truncated mod 2^AB (wrap silently).
- doPooling = latched cfg_pool while busy, else 0.
- Addresses hold their last value outside MAC/WRITE. nWWrite is asserted only in WRITE.
- abort: in any non-IDLE state, go to IDLE next cycle. Outputs drop to their idle values; no done, no swap, and a WRITE in the same cycle is still performed.
- start and abort in the same cycle in IDLE: abort wins, start is dropped.

Optional Feature:
CONV_SEQ_STATS_EN
- Defined: adds output stat_cycles [31:0]. It clears on accepted start, increments every busy cycle, saturates at all-ones, and holds after done/abort.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package: state encoding (seq_state_t, 3-bit), PIPE_LAT default, cfg field widths CW/KW.
- One natural sub-module, conv_seq_addr_gen: combinational/registered address generator taking orow, ocol, kr, kc and the bases; keeps multipliers out of the FSM.

Test Plan:
- K=3, R=2, C=2, stride=4, bases 0/100/200, start → 4 writes at nWriteAddress 100,101,102,103; done 50 cycles after start; readBufferSelect 0→1.
- Same layer, check the first window: nReadAddress sequence 0,1,2,4,5,6,8,9,10 and kBuffAddress 200..208; peClear only on the first tap.
- cfg_k=0, start → cfg_err pulse 2 cycles after start; no nWWrite; readBufferSelect unchanged; busy high only 1 cycle.
- abort asserted during the second position's MAC → IDLE next cycle, exactly 1 write observed, no done, readBufferSelect unchanged.
- in_base=2046, K=2, R=C=1, stride=2 → nReadAddress 2046, 2047, 0, 1 (wrap).
- RST_N low mid-DRAIN → all outputs 0 immediately; after release, a fresh start runs a full layer correctly.
